fifo_reader: RTL and testbench

- Read-side controller for the synchronous FIFO: pops words through the FIFO read port (empty/RD/dataOut) and presents them on a valid/ready output stream.
- Absorbs the FIFO's 1-cycle read latency with a 2-entry skid buffer, so it sustains one word per cycle under no backpressure.
- Optional pacing gap between reads, for rate-limited consumers.
- Mirror of the incrementing-pattern writer used in FIFO bring-up.

---
 rtl/fifo_reader_if.sv | 23 ++
 rtl/fifo_reader.sv | 129 ++++++++++++
 tb/tb_fifo_reader.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_reader_if.sv
// rtl/fifo_reader_if.sv - FIFO read port and output stream bundle for fifo_reader
interface fifo_reader_if #(
   parameter int DATA_WIDTH = 4
);
   logic                  fifo_empty;
   logic                  fifo_rd;
   logic [DATA_WIDTH-1:0] fifo_dout;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   // reader side
   modport master (
      input  fifo_empty, fifo_dout, out_ready,
      output fifo_rd, out_data, out_valid
   );

   // FIFO / downstream side
   modport slave (
      output fifo_empty, fifo_dout, out_ready,
      input  fifo_rd, out_data, out_valid
   );
endinterface

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - FIFO read controller with 2-entry skid buffer; optional READER_SEQ_CHECK_EN
module fifo_reader #(
   parameter int DATA_WIDTH = 4,
   parameter int GAP        = 0,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   fifo_reader_if.master        bus,
   output logic [CNT_WIDTH-1:0] word_count,
   output logic                 seq_err
);
   localparam int GW = $clog2(GAP + 2);

   typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;

   state_t                state_q, state_d;
   logic [GW-1:0]         gap_q, gap_d;
   logic                  inflight_q;
   logic [1:0]            count_q;
   logic [DATA_WIDTH-1:0] head_q, tail_q;
   logic [CNT_WIDTH-1:0]  wc_q;
   logic                  pop;
   logic                  rd;
   logic [2:0]            occ;

   assign pop = (count_q != 2'd0) & bus.out_ready;
   // occupancy the buffer will reach if a read issued now: credit limit of 2
   assign occ = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign rd  = ~rst & (state_q == ACTIVE) & enable & ~bus.fifo_empty & (occ < 3'd2);

   assign bus.fifo_rd   = rd;
   assign bus.out_data  = head_q;
   assign bus.out_valid = (count_q != 2'd0);
   assign word_count    = wc_q;

   // state and gap counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
      end
   end

   // next-state: pacing gap after each read when GAP > 0
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      case (state_q)
         IDLE: begin
            if (enable) state_d = ACTIVE;
         end
         ACTIVE: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (rd && (GAP > 0)) begin
               state_d = HOLD;
               gap_d   = GW'(GAP);
            end
         end
         HOLD: begin
            gap_d = gap_q - GW'(1);
            if (gap_q <= GW'(1)) state_d = enable ? ACTIVE : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // skid buffer: read data lands one cycle after the strobe, kept in order
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q <= 1'b0;
         count_q    <= 2'd0;
         head_q     <= '0;
         tail_q     <= '0;
         wc_q       <= '0;
      end else begin
         inflight_q <= rd;
         if (pop) wc_q <= wc_q + CNT_WIDTH'(1);
         case ({inflight_q, pop})
            2'b10: begin
               if (count_q == 2'd0) head_q <= bus.fifo_dout;
               else                 tail_q <= bus.fifo_dout;
               count_q <= count_q + 2'd1;
            end
            2'b01: begin
               head_q  <= tail_q;
               count_q <= count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  head_q <= bus.fifo_dout;
               end else begin
                  head_q <= tail_q;
                  tail_q <= bus.fifo_dout;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef READER_SEQ_CHECK_EN
   logic                  seen_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] exp_q;

   // incrementing-pattern check on every word accepted downstream
   always_ff @(posedge clk) begin
      if (rst) begin
         seen_q <= 1'b0;
         err_q  <= 1'b0;
         exp_q  <= '0;
      end else if (pop) begin
         seen_q <= 1'b1;
         exp_q  <= head_q + DATA_WIDTH'(1);
         if (seen_q && (head_q != exp_q)) err_q <= 1'b1;
      end
   end

   assign seq_err = err_q;
`else
   assign seq_err = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - directed bench for fifo_reader (GAP=0 and GAP=5 instances)
module tb_fifo_reader;
`ifdef READER_SEQ_CHECK_EN
   localparam logic SEQ = 1'b1;
`else
   localparam logic SEQ = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst0, rst1, en0, en1;
   logic [7:0] wc0, wc1;
   logic       se0, se1;
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 clk = ~clk;

   fifo_reader_if #(.DATA_WIDTH(4)) bus0 ();
   fifo_reader_if #(.DATA_WIDTH(4)) bus1 ();

   fifo_reader #(.DATA_WIDTH(4), .GAP(0), .CNT_WIDTH(8)) u0 (
      .clk(clk), .rst(rst0), .enable(en0), .bus(bus0.master),
      .word_count(wc0), .seq_err(se0)
   );
   fifo_reader #(.DATA_WIDTH(4), .GAP(5), .CNT_WIDTH(8)) u1 (
      .clk(clk), .rst(rst1), .enable(en1), .bus(bus1.master),
      .word_count(wc1), .seq_err(se1)
   );

   // behavioural FIFOs with one-cycle read latency
   logic [3:0] mem0 [256];
   logic [3:0] mem1 [256];
   logic [7:0] wp0 = 8'd0, rp0 = 8'd0, wp1 = 8'd0, rp1 = 8'd0;

   assign bus0.fifo_empty = (wp0 == rp0);
   assign bus1.fifo_empty = (wp1 == rp1);

   always @(posedge clk) begin
      if (bus0.fifo_rd) begin
         bus0.fifo_dout <= mem0[rp0];
         rp0 <= rp0 + 8'd1;
      end
      if (bus1.fifo_rd) begin
         bus1.fifo_dout <= mem1[rp1];
         rp1 <= rp1 + 8'd1;
      end
   end

   task automatic push0(input logic [3:0] v);
      mem0[wp0] = v;
      wp0 = wp0 + 8'd1;
   endtask

   task automatic push1(input logic [3:0] v);
      mem1[wp1] = v;
      wp1 = wp1 + 8'd1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      int         nrd, ng, seen4, fr;
      logic       anyrd, anyv;
      int         t[$];
      logic [3:0] e3 [3];

      rst0 = 1'b1; rst1 = 1'b1; en0 = 1'b1; en1 = 1'b0;
      bus0.out_ready = 1'b1;
      bus1.out_ready = 1'b1;

      // reset with data available and enable high
      for (int i = 0; i < 4; i++) push0(4'(i));
      repeat (3) begin
         @(negedge clk);
         check("rst_rd", bus0.fifo_rd, 0);
         check("rst_valid", bus0.out_valid, 0);
         check("rst_wc", wc0, 0);
      end
      rst0 = 1'b0;

      // back-to-back stream 0..3
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check($sformatf("stream_rd%0d", k), bus0.fifo_rd, (k <= 4) ? 1 : 0);
         check($sformatf("stream_valid%0d", k), bus0.out_valid, (k >= 3 && k <= 6) ? 1 : 0);
         if (k >= 3 && k <= 6) check($sformatf("stream_data%0d", k), bus0.out_data, k - 3);
      end
      check("stream_wc", wc0, 4);

      // backpressure: two reads then hold
      rst0 = 1'b1;
      bus0.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push0(4'(i));
      @(negedge clk);
      rst0 = 1'b0;
      nrd = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus0.fifo_rd) nrd++;
      end
      check("bp_reads", nrd, 2);
      check("bp_rd_low", bus0.fifo_rd, 0);
      check("bp_valid", bus0.out_valid, 1);
      check("bp_head", bus0.out_data, 0);
      bus0.out_ready = 1'b1;
      #1;
      ng = 0;
      repeat (10) begin
         if (bus0.out_valid && bus0.out_ready) begin
            check($sformatf("bp_data%0d", ng), bus0.out_data, ng);
            ng++;
         end
         @(negedge clk);
      end
      check("bp_count", ng, 4);
      check("bp_wc", wc0, 4);

      // empty FIFO, then a wrapping stream E,F,0
      rst0 = 1'b1;
      @(negedge clk);
      rst0 = 1'b0;
      anyrd = 1'b0; anyv = 1'b0;
      repeat (20) begin
         @(negedge clk);
         anyrd |= bus0.fifo_rd;
         anyv  |= bus0.out_valid;
      end
      check("empty_rd", anyrd, 0);
      check("empty_valid", anyv, 0);
      push0(4'hE); push0(4'hF); push0(4'h0);
      e3[0] = 4'hE; e3[1] = 4'hF; e3[2] = 4'h0;
      ng = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus0.out_valid && ng < 3) begin
            check($sformatf("wrap_data%0d", ng), bus0.out_data, e3[ng]);
            ng++;
         end
      end
      check("wrap_count", ng, 3);
      check("wrap_wc", wc0, 3);
      check("wrap_seq_err", se0, 0);

      // sequence gap 1,2,4,5
      rst0 = 1'b1;
      push0(4'd1); push0(4'd2); push0(4'd4); push0(4'd5);
      @(negedge clk);
      rst0 = 1'b0;
      seen4 = -1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (seen4 >= 0 && c == seen4 + 1) check("seq_err_rise", se0, SEQ);
         if (bus0.out_valid && bus0.out_data == 4'd4) begin
            check("seq_err_pre", se0, 0);
            seen4 = c;
         end
      end
      check("seq_word4_seen", (seen4 >= 0) ? 1 : 0, 1);
      check("seq_err_hold", se0, SEQ);
      check("seq_wc", wc0, 4);

      // GAP=5: reads six cycles apart
      en1 = 1'b1;
      push1(4'd0); push1(4'd1); push1(4'd2);
      @(negedge clk);
      rst1 = 1'b0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (bus1.fifo_rd) t.push_back(c);
      end
      check("gap_reads", t.size(), 3);
      if (t.size() == 3) begin
         check("gap_space1", t[1] - t[0], 6);
         check("gap_space2", t[2] - t[1], 6);
      end
      check("gap_wc", wc1, 3);

      // GAP=5 with enable dropped after the first read
      rst1 = 1'b1;
      push1(4'd3); push1(4'd4); push1(4'd5);
      @(negedge clk);
      rst1 = 1'b0;
      fr = 0;
      for (int c = 0; c < 10 && fr == 0; c++) begin
         @(negedge clk);
         if (bus1.fifo_rd) fr = 1;
      end
      check("drop_first_rd", fr, 1);
      @(negedge clk);
      en1 = 1'b0;
      nrd = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus1.fifo_rd) nrd++;
      end
      check("drop_no_reads", nrd, 0);
      check("drop_wc", wc1, 1);
      en1 = 1'b1;
      #1;
      check("drop_idle_rd0", bus1.fifo_rd, 0);
      @(negedge clk);
      check("drop_idle_rd1", bus1.fifo_rd, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
